multiprec_add_ctrl: RTL and testbench

Sequencer that performs NIBBLES*4-bit add/subtract by time-multiplexing the team's existing 4-bit ripple-carry adder_nbit, least-significant nibble first.
- Latches wide operands on a start handshake, drives one nibble slice per cycle into the external adder and chains carry through a register.
- Publishes the full result, carry and signed-overflow flags with a one-cycle done pulse.
- Sits between the register file/bus logic and a single shared adder_nbit instance.

---
 rtl/multiprec_add_ctrl.sv | 161 ++++++++++++++++
 tb/tb_multiprec_add_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiprec_add_ctrl.sv
// Multi-precision add/subtract sequencer driving one shared 4-bit ripple-carry adder, LS nibble first.
// Latency: start accepted at edge k, done pulses in the cycle after edge k+NIBBLES, ready one cycle later.
// Backpressure: start is honoured only while ready=1; requests during RUN/DONE are dropped, not queued.
module multiprec_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic                 cin,
    input  logic [4*NIBBLES-1:0] a_in,
    input  logic [4*NIBBLES-1:0] b_in,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum_out,
    output logic                 carry_out,
    output logic                 ovf,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [IW-1:0]   idx;
    logic            carry_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            sub_reg;
    logic            cin_reg;
    logic [W-1:0]    acc;
    logic [W-1:0]    acc_nxt;

    logic            accept;
    logic            last_slice;
    logic [IW+1:0]   bit_base;
    logic [3:0]      a_slice;
    logic [3:0]      b_slice;
    logic            b_eff_msb;
    logic            ovf_nxt;

    // A start is only taken in IDLE; everything else ignores it.
    assign accept     = (state == S_IDLE) && start;
    assign last_slice = (idx == IW'(NIBBLES - 1));
    assign bit_base   = {idx, 2'b00};
    assign a_slice    = a_reg[bit_base +: 4];
    assign b_slice    = b_reg[bit_base +: 4];

    // Effective B sign bit (inverted in subtract mode) for the signed-overflow rule.
    assign b_eff_msb  = b_reg[W-1] ^ sub_reg;

    // Accumulator with the current adder slice merged in, so the final slice can
    // feed the result registers on the same edge it is produced.
    always_comb begin
        acc_nxt = acc;
        if (state == S_RUN) begin
            acc_nxt[bit_base +: 4] = add_sum;
        end
    end

    // Overflow: operands share a sign but the result sign differs.
    assign ovf_nxt = (a_reg[W-1] == b_eff_msb) && (acc_nxt[W-1] != a_reg[W-1]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN for NIBBLES cycles, one DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_slice) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs: status flags, and adder inputs held at zero outside RUN so the shared adder stays quiet.
    always_comb begin
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        case (state)
            S_IDLE: ready = 1'b1;
            S_RUN: begin
                busy    = 1'b1;
                add_a   = a_slice;
                add_b   = b_slice ^ {4{sub_reg}};
                add_cin = (idx == '0) ? (cin_reg | sub_reg) : carry_reg;
            end
            S_DONE: done = 1'b1;
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    // Operand capture, slice index and carry chaining.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            cin_reg   <= 1'b0;
            acc       <= '0;
        end else if (accept) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= a_in;
            b_reg     <= b_in;
            sub_reg   <= sub;
            cin_reg   <= cin;
            acc       <= '0;
        end else if (state == S_RUN) begin
            acc       <= acc_nxt;
            carry_reg <= add_cout;
            if (!last_slice) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Result registers load on the final slice so they are valid exactly when done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_out   <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
        end else if ((state == S_RUN) && last_slice) begin
            sum_out   <= acc_nxt;
            carry_out <= add_cout;
            ovf       <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_multiprec_add_ctrl.sv
module tb_multiprec_add_ctrl;

    localparam int N = 4;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          sub;
    logic          cin;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          ready;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum_out;
    logic          carry_out;
    logic          ovf;
    logic [3:0]    add_a;
    logic [3:0]    add_b;
    logic          add_cin;
    logic [3:0]    add_sum;
    logic          add_cout;

    int            passed = 0;
    int            failed = 0;
    int            total  = 0;
    logic [17:0]   sb_q[$];
    logic [W-1:0]  prev_sum;

    always #5 clk = ~clk;

    // Shared 4-bit combinational adder in the environment.
    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    multiprec_add_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .cin       (cin),
        .a_in      (a_in),
        .b_in      (b_in),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .carry_out (carry_out),
        .ovf       (ovf),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width arithmetic, packed as {sum[15:0], carry, ovf}.
    function automatic logic [17:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s, input logic c);
        logic [W-1:0] bx;
        logic         ci;
        logic [W:0]   r;
        logic         v;
        bx = s ? ~b : b;
        ci = s ? 1'b1 : c;
        r  = {1'b0, a} + {1'b0, bx} + 17'(ci);
        v  = (a[W-1] == bx[W-1]) && (r[W-1] != a[W-1]);
        return {r[W-1:0], r[W], v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for done; counts cycles and busy cycles, records add_cin per slice,
    // and checks that sum_out does not move before done.
    task automatic wait_done(input string tag, input logic rand_a, output int cyc,
                             output int busy_cnt, output logic [7:0] cin_seq);
        logic held;
        cyc      = 0;
        busy_cnt = 0;
        cin_seq  = '0;
        held     = 1'b1;
        while (!done && cyc < 20) begin
            if (busy) begin
                if (busy_cnt < 8) cin_seq[busy_cnt] = add_cin;
                busy_cnt++;
            end
            if (sum_out !== prev_sum) held = 1'b0;
            tick();
            if (rand_a) a_in = 16'($urandom);
            cyc++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        chk({tag, "_sum_held"}, 32'(held), 32'd1);
    endtask

    task automatic compare_result(input string tag);
        logic [17:0] e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_sum"}, 32'(sum_out), 32'(e[17:2]));
            chk({tag, "_carry"}, 32'(carry_out), 32'(e[1]));
            chk({tag, "_ovf"}, 32'(ovf), 32'(e[0]));
            prev_sum = e[17:2];
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c, output logic [7:0] cin_seq);
        int cyc;
        int bc;
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        sb_q.push_back(model(a, b, s, c));
        a_in  = a;
        b_in  = b;
        sub   = s;
        cin   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        a_in  = 16'($urandom);
        b_in  = 16'($urandom);
        sub   = 1'($urandom);
        cin   = 1'($urandom);
        wait_done(tag, 1'b0, cyc, bc, cin_seq);
        chk({tag, "_latency"}, 32'(cyc), 32'(N));
        chk({tag, "_busy_cycles"}, 32'(bc), 32'(N));
        compare_result(tag);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_ready_back"}, 32'(ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cs;
        int         cyc;
        int         bc;
        logic       saw_done;

        rst      = 1'b1;
        start    = 1'b0;
        sub      = 1'b0;
        cin      = 1'b0;
        a_in     = '0;
        b_in     = '0;
        prev_sum = '0;
        tick();
        tick();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum_out), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_adder_in", 32'({add_a, add_b, add_cin}), 32'd0);
        rst = 1'b0;
        tick();

        run_op("add1", 16'h1234, 16'h1111, 1'b0, 1'b0, cs);
        run_op("addwrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, cs);
        chk("addwrap_cin_chain", 32'(cs[3:0]), 32'h0000_000E);
        run_op("addovf", 16'h7FFF, 16'h0000, 1'b0, 1'b1, cs);
        chk("addovf_cin0", 32'(cs[0]), 32'd1);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0, cs);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, cs);
        chk("idle_adder_quiet", 32'({add_a, add_b, add_cin}), 32'd0);

        // Start held high with a_in changing: only IDLE-sampled operands count.
        sb_q.push_back(model(16'h0100, 16'h0001, 1'b0, 1'b0));
        a_in  = 16'h0100;
        b_in  = 16'h0001;
        sub   = 1'b0;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        a_in = 16'($urandom);
        wait_done("b2b1", 1'b1, cyc, bc, cs);
        chk("b2b1_latency", 32'(cyc), 32'(N));
        compare_result("b2b1");
        a_in = 16'($urandom);
        tick();
        chk("b2b_ready_after_done", 32'(ready), 32'd1);
        sb_q.push_back(model(16'h0200, 16'h0002, 1'b0, 1'b0));
        a_in = 16'h0200;
        b_in = 16'h0002;
        tick();
        chk("b2b_accept", 32'(busy), 32'd1);
        a_in = 16'($urandom);
        wait_done("b2b2", 1'b1, cyc, bc, cs);
        compare_result("b2b2");
        start = 1'b0;
        tick();

        // Abort mid-RUN at idx=2.
        a_in  = 16'h1234;
        b_in  = 16'h1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum", 32'(sum_out), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        prev_sum = '0;
        run_op("post_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, cs);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
